bsg_chip_mc_link_token_rx: RTL
==============================

// Module: bsg_chip_mc_link_token_rx
// PURPOSE
//  Host-side receiving endpoint for one manycore token link (data/v/token) driven by
//  the core complex, e.g. mc_fwd_link_*_o (chip->host requests). Buffers incoming
//  packets in an els_p-deep FIFO and presents them to the host fabric with valid/yumi.
//  Returns flow-control credit to the sender as decimated token pulses.
//  Sender and receiver share one clock domain.
// PARAMETERS
//  width_p              128  link packet width; set to mc_fwd_width or mc_rev_width
//  els_p                16   FIFO depth = credits granted to sender at reset; power of 2
//  lg_token_decimation_p 2   one token pulse per 2**lg_token_decimation_p dequeued words
// PORTS
//  clk_i            in   1        link/core clock
//  reset_i          in   1        asynchronous reset, active-high
//  link_data_i      in   width_p  packet from sender
//  link_v_i         in   1        packet valid; sender spends one credit per cycle high
//  link_token_o     out  1        one-cycle credit pulse = 2**lg_token_decimation_p credits
//  data_o           out  width_p  FIFO head packet
//  v_o              out  1        FIFO non-empty
//  yumi_i           in   1        consumer takes data_o this cycle; legal only when v_o=1
//  overflow_o       out  1        sticky: packet arrived with FIFO full and no dequeue
//  max_occupancy_o  out  $clog2(els_p+1)  high-water mark (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): rd/wr pointers=0, occupancy=0, v_o=0,
//    link_token_o=0, token counter=0, overflow_o=0, max_occupancy_o=0; data_o don't-care.
//  - No ready toward sender: link_v_i=1 always enqueues unless FIFO full.
//  - Enqueue at edge t; v_o/data_o reflect it from cycle t+1 (1-cycle latency, registered).
//  - Dequeue on yumi_i=1 & v_o=1; head advances next edge. yumi_i with v_o=0 is ignored.
//  - Full & link_v_i & yumi_i same cycle: dequeue and enqueue both happen, no overflow.
//  - Full & link_v_i & !yumi_i: word dropped, overflow_o set until reset.
//  - Empty & link_v_i & yumi_i: yumi ignored (no bypass), word enqueued.
//  - Pointers are $clog2(els_p) bits, wrap modulo els_p; occupancy counter 0..els_p.
//  - Token counter (lg_token_decimation_p bits) increments per dequeue. On wrap to 0,
//    link_token_o pulses high for exactly one cycle (registered, cycle after the dequeue).
//    Back-to-back dequeues at full rate give a pulse every 2**lg cycles, never merged.
//  - Credits stranded in counter (< 2**lg) are not returned until more dequeues occur.
//    Sender must start with els_p credits; els_p must be a multiple of 2**lg.
//  - Elaboration assertion: els_p power of 2, els_p >= 2**lg_token_decimation_p.
// CONFIGURATION
//  BSG_MC_LINK_RX_STATS_EN
//   defined: max_occupancy_o registers the peak FIFO occupancy since reset;
//            updates the cycle after the occupancy rises.
//   undefined: max_occupancy_o tied to 0, no stats logic.
//   Port list is identical either way.
// TESTING
//  1 reset; 1 packet 0xA5, no yumi -> v_o=1 next cycle, data_o=0xA5, token_o stays 0
//  2 lg=2: stream 8 packets, yumi held 1 -> 8 dequeues, exactly 2 token pulses,
//    each 1 cycle wide, 4 cycles apart; data order preserved
//  3 els_p=16: 16 packets, yumi=0 -> occupancy 16, overflow_o=0; 17th packet -> overflow_o=1
//    sticky, 17th word absent from output
//  4 full + link_v_i + yumi_i same cycle -> no overflow; occupancy stays 16; new word at tail
//  5 reset_i mid-stream (occupancy 5, token counter 3) -> v_o, token_o, overflow_o
//    drop to 0 immediately without clock; after release, first packet appears normally
//  6 STATS_EN on: 10 queued, drain to 0, 3 queued -> max_occupancy_o=10; STATS_EN off -> 0

Source files
------------

// File: rtl/bsg_chip_mc_link_token_rx.sv
// bsg_chip_mc_link_token_rx: link receive FIFO that returns credits as decimated token pulses.
// Define BSG_MC_LINK_RX_STATS_EN to track the peak FIFO occupancy on max_occupancy_o.
module bsg_chip_mc_link_token_rx #(
    parameter int width_p = 128,
    parameter int els_p = 16,
    parameter int lg_token_decimation_p = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [width_p-1:0]           link_data_i,
    input  logic                         link_v_i,
    output logic                         link_token_o,
    output logic [width_p-1:0]           data_o,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic                         overflow_o,
    output logic [$clog2(els_p+1)-1:0]   max_occupancy_o
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);
    localparam int tok_w = lg_token_decimation_p > 0 ? lg_token_decimation_p : 1;
    localparam logic [tok_w-1:0] tok_last = tok_w'((1 << lg_token_decimation_p) - 1);
    if (els_p < 2 || (els_p & (els_p - 1)) != 0 || els_p < (1 << lg_token_decimation_p)) begin : g_param_check
        $error("els_p must be a power of 2 and at least 2**lg_token_decimation_p");
    end
    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rd_ptr, wr_ptr;
    logic [cnt_w-1:0]   count;
    logic [tok_w-1:0]   tok_cnt;
    logic               full, deq, enq;
    assign v_o    = count != '0;
    assign data_o = mem[rd_ptr];
    // a full FIFO still accepts when the head leaves in the same cycle
    always_comb begin
        full = count == cnt_w'(els_p);
        deq  = yumi_i & v_o;
        enq  = link_v_i & (~full | deq);
    end
    always_ff @(posedge clk_i)
        if (enq) mem[wr_ptr] <= link_data_i;
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            tok_cnt      <= '0;
            link_token_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + ptr_w'(1);
            if (deq) rd_ptr <= rd_ptr + ptr_w'(1);
            count <= count + cnt_w'(enq) - cnt_w'(deq);
            if (deq) tok_cnt <= tok_cnt == tok_last ? '0 : tok_cnt + tok_w'(1);
            link_token_o <= deq & (tok_cnt == tok_last);
            if (link_v_i & full & ~deq) overflow_o <= 1'b1;
        end
`ifdef BSG_MC_LINK_RX_STATS_EN
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) max_occupancy_o <= '0;
        else if (count > max_occupancy_o) max_occupancy_o <= count;
`else
    assign max_occupancy_o = '0;
`endif
endmodule
